// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encodings, boolean constants and a small helper.
package pipeline_stall_ctrl_pkg;

    // Controller states: normal flow, one-cycle load-use bubble, frozen on data memory
    typedef enum logic [1:0] {
        STALL_RUN  = 2'd0,
        STALL_LU   = 2'd1,
        STALL_MEMW = 2'd2
    } stall_state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // The MEM stage is blocked when a request is outstanding and not completed this cycle
    function automatic logic mem_busy_f(input logic req, input logic ack);
        return req & ~ack;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/handshake inputs and per-stage enable/flush outputs of the stall controller.
// master = pipeline side driving the hazard information, slave = the controller.
interface pipeline_stall_ctrl_if;

    logic mem_ex_hazard;
    logic branch_taken;
    logic dmem_req;
    logic dmem_ack;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;

    modport master (
        output mem_ex_hazard, branch_taken, dmem_req, dmem_ack,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    modport slave (
        input  mem_ex_hazard, branch_taken, dmem_req, dmem_ack,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count requested events, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns load-use hazards, taken branches and
// data-memory waits into per-stage enables and bubble inserts, and keeps
// watchdog, protocol-error and performance state.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_stall_ctrl_if.slave    ctl,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_events,
    output logic                    hazard_err,
    output logic                    dmem_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    stall_state_t      state;
    stall_state_t      state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_busy;
    logic              branch_flush;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign mem_busy = mem_busy_f(ctl.dmem_req, ctl.dmem_ack);

    // State register; a reset during a memory wait simply abandons it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STALL_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: every state leaves the same way, so LU_STALL only persists while the hazard does
    always_comb begin
        state_next = STALL_RUN;
        if (mem_busy) begin
            state_next = STALL_MEMW;
        end else if (ctl.mem_ex_hazard) begin
            state_next = STALL_LU;
        end
    end

    // Enables/flushes by priority: memory wait, load-use stall, taken branch, free run
    always_comb begin
        pc_en        = TRUE;
        ifid_en      = TRUE;
        idex_en      = TRUE;
        exmem_en     = TRUE;
        memwb_en     = TRUE;
        ifid_flush   = FALSE;
        idex_flush   = FALSE;
        exmem_flush  = FALSE;
        memwb_flush  = FALSE;
        branch_flush = FALSE;
        if (!rst_n) begin
            pc_en       = FALSE;
            ifid_en     = FALSE;
            idex_en     = FALSE;
            exmem_en    = FALSE;
            memwb_en    = FALSE;
            ifid_flush  = TRUE;
            idex_flush  = TRUE;
            exmem_flush = TRUE;
            memwb_flush = TRUE;
        end else if (mem_busy) begin
            pc_en       = FALSE;
            ifid_en     = FALSE;
            idex_en     = FALSE;
            exmem_en    = FALSE;
            memwb_flush = TRUE;
        end else if (ctl.mem_ex_hazard) begin
            pc_en       = FALSE;
            ifid_en     = FALSE;
            idex_en     = FALSE;
            exmem_flush = TRUE;
        end else if (ctl.branch_taken) begin
            ifid_flush   = TRUE;
            idex_flush   = TRUE;
            branch_flush = TRUE;
        end
    end

    assign ctl.pc_en       = pc_en;
    assign ctl.ifid_en     = ifid_en;
    assign ctl.idex_en     = idex_en;
    assign ctl.exmem_en    = exmem_en;
    assign ctl.memwb_en    = memwb_en;
    assign ctl.ifid_flush  = ifid_flush;
    assign ctl.idex_flush  = idex_flush;
    assign ctl.exmem_flush = exmem_flush;
    assign ctl.memwb_flush = memwb_flush;

    // Watchdog: counts consecutive busy cycles (holding at the limit) and clears when memory frees up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!mem_busy) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky timeout once the TIMEOUT-th consecutive busy cycle is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_timeout <= FALSE;
        end else if (mem_busy && (wait_cnt == WAIT_LAST)) begin
            dmem_timeout <= TRUE;
        end
    end

    // Sticky protocol error: the hazard must have cleared after one bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_err <= FALSE;
        end else if ((state == STALL_LU) && ctl.mem_ex_hazard) begin
            hazard_err <= TRUE;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & ~pc_en),
        .value (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_flush),
        .value (flush_events)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios followed by
// random hazard/branch/memory traffic, checked against a cycle-level model.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             hazard_err;
    logic             dmem_timeout;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctl          (bus.slave),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
        .hazard_err   (hazard_err),
        .dmem_timeout (dmem_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the previous cycle did, how long memory has blocked, totals
    bit prev_lu_bubble;
    int busy_run;
    int stall_m;
    int flush_m;
    bit herr_m;
    bit tmo_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any disagreement
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] ctrl_vec();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
    endfunction

    task automatic checkRegs();
        checkOutput("stall_cycles", 32'(stall_cycles), 32'(stall_m));
        checkOutput("flush_events", 32'(flush_events), 32'(flush_m));
        checkOutput("hazard_err", 32'(hazard_err), 32'(herr_m));
        checkOutput("dmem_timeout", 32'(dmem_timeout), 32'(tmo_m));
    endtask

    // Hold reset for three cycles, then release with idle inputs and a fresh model
    task automatic doReset();
        rst_n = 1'b0;
        bus.mem_ex_hazard = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.dmem_ack      = 1'b0;
        prev_lu_bubble = 1'b0;
        busy_run = 0;
        stall_m  = 0;
        flush_m  = 0;
        herr_m   = 1'b0;
        tmo_m    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("reset_ctrl", 32'(ctrl_vec()), 32'(9'b00000_1111));
            checkRegs();
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_ctrl", 32'(ctrl_vec()), 32'(9'b11111_0000));
        checkRegs();
    endtask

    // One clock cycle: drive inputs, check the combinational controls, advance model, check state
    task automatic applyStimulus(input bit h, input bit b, input bit r, input bit a);
        logic [8:0] exp_ctrl;
        bit busy;
        bit branch_flush;
        bus.mem_ex_hazard = h;
        bus.branch_taken  = b;
        bus.dmem_req      = r;
        bus.dmem_ack      = a;
        busy = r && !a;
        branch_flush = 1'b0;
        if (busy)       exp_ctrl = 9'b00001_0001;
        else if (h)     exp_ctrl = 9'b00011_0010;
        else if (b) begin
            exp_ctrl = 9'b11111_1100;
            branch_flush = 1'b1;
        end
        else            exp_ctrl = 9'b11111_0000;
        #1;
        checkOutput("ctrl", 32'(ctrl_vec()), 32'(exp_ctrl));

        if (prev_lu_bubble && h) herr_m = 1'b1;
        prev_lu_bubble = !busy && h;
        if (busy) begin
            if (busy_run < TIMEOUT) busy_run++;
            if (busy_run >= TIMEOUT) tmo_m = 1'b1;
        end else begin
            busy_run = 0;
        end
        if (!exp_ctrl[8] && stall_m < CNT_MAX) stall_m++;
        if (branch_flush && flush_m < CNT_MAX) flush_m++;

        @(posedge clk);
        #1;
        checkRegs();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.mem_ex_hazard = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.dmem_ack      = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        // Single load-use bubble, then free run
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("lu_single_stalls", 32'(stall_cycles), 32'd1);
        checkOutput("lu_single_err", 32'(hazard_err), 32'd0);

        // Hazard lingering a second cycle is a protocol error that sticks
        doReset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lu_double_err", 32'(hazard_err), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("lu_double_stalls", 32'(stall_cycles), 32'd2);
        checkOutput("lu_err_sticky", 32'(hazard_err), 32'd1);

        // Five-cycle memory wait then ack
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("memw_timeout_set", 32'(dmem_timeout), 32'd1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("memw_stalls", 32'(stall_cycles), 32'd8);

        // Branch masked by load-use, then taken alone
        doReset();
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("branch_flushes", 32'(flush_events), 32'd1);

        // Watchdog boundary: three busy cycles do not trip it, the fourth does
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("tmo_before", 32'(dmem_timeout), 32'd0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("tmo_at_limit", 32'(dmem_timeout), 32'd1);

        // Counter saturation
        doReset();
        for (int i = 0; i < CNT_MAX + 3; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("flush_saturate", 32'(flush_events), 32'(CNT_MAX));

        // Random traffic with occasional resets
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) doReset();
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) < 3,  $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Control end of the EX-stage forwarding path. It consumes the load-use hazard flag from the forwarding mux, the EX branch decision and the MEM-stage data-memory handshake.
- It drives per-stage enable and flush (bubble) signals for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Registered state tracks multi-cycle memory waits, a timeout watchdog, protocol-error flags and saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 64: max consecutive MEM_WAIT cycles before dmem_timeout sets.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_ex_hazard  in  1  EX operand depends on a load currently in MEM.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- dmem_req  in  1  MEM stage has an outstanding data-memory access.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (NOP, reg_write_en=0) instead of the upstream stage.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.
- flush_events  out  CNT_W  saturating count of branch-flush cycles.
- hazard_err  out  1  sticky: mem_ex_hazard asserted in the cycle right after a load-use stall.
- dmem_timeout  out  1  sticky: MEM_WAIT lasted TIMEOUT cycles.

Behaviour:
- Reset (rst_n low, async):
  - all *_en = 0 and all *_flush = 1;
  - state = RUN;
  - counters = 0;
  - sticky flags = 0.
  - Reset mid-MEM_WAIT abandons the access; the MEM stage owns request cancel.
- Enables and flushes are combinational from the inputs and the current state (zero latency). State, counters and flags update on the rising clk edge.
- Let mem_busy = dmem_req & ~dmem_ack.
- Priority, highest first:
  1. mem_busy: all *_en = 0 except memwb_en = 1, memwb_flush = 1 (WB drains, bubble enters WB); other flushes 0.
  2. mem_ex_hazard: pc_en = ifid_en = idex_en = 0; exmem_en = 1, exmem_flush = 1; memwb_en = 1.
     - branch_taken is ignored this cycle because the branch operand is not valid yet.
  3. branch_taken: all *_en = 1, ifid_flush = 1, idex_flush = 1. PC loads the target.
  4. otherwise (RUN): all *_en = 1, all *_flush = 0.
- A same-cycle dmem_ack clears mem_busy, so rule 2/3/4 applies in that cycle.
- FSM states: RUN, LU_STALL, MEM_WAIT.
  - RUN: mem_busy -> MEM_WAIT; else mem_ex_hazard -> LU_STALL; else RUN.
  - LU_STALL: lasts exactly one cycle.
    - If mem_ex_hazard is still high here, set hazard_err. The stall still repeats per rule 2.
    - Next state: mem_busy -> MEM_WAIT; mem_ex_hazard -> LU_STALL; else RUN.
  - MEM_WAIT: wait counter increments each cycle with mem_busy.
    - When the counter reaches TIMEOUT-1 while still busy, set dmem_timeout; the pipeline stays frozen.
    - ~mem_busy clears the counter and transitions like RUN.
- stall_cycles increments every cycle with pc_en = 0 and rst_n high. flush_events increments on each rule-3 cycle. Both hold at 2^CNT_W-1.
- Sticky flags clear only on reset.

Decomposition:
- Shared defines file: state encodings (STALL_RUN, STALL_LU, STALL_MEMW) and `TRUE/`FALSE.
- Sub-module sat_counter (parameter W; inc, value; async active-low reset), instantiated twice. The watchdog counter is inline.

Test Plan:
- Reset held 3 cycles, then released with all inputs 0 -> during reset all en=0, all flush=1; after release all en=1, all flush=0, counters 0.
- mem_ex_hazard=1 for one cycle -> that cycle pc/ifid/idex_en=0, exmem_flush=1; next cycle RUN; stall_cycles=1, hazard_err=0.
- mem_ex_hazard held 2 cycles -> hazard_err=1 after the second edge and stays 1; stall_cycles=2.
- dmem_req=1, ack low 5 cycles then high -> 5 frozen cycles with memwb_flush=1; on the ack cycle all en=1; stall_cycles=5.
- branch_taken=1 together with mem_ex_hazard=1, then branch_taken alone -> first cycle stall and no flush; second cycle ifid_flush=idex_flush=1; flush_events=1.
- TIMEOUT=4, dmem_req=1, ack never -> dmem_timeout=1 after the 4th busy edge; CNT_W=2 with 5 stalls -> stall_cycles saturates at 3.
